// File: rtl/gb_apu_pkg.sv
// rtl/gb_apu_pkg.sv - shared constants for the APU length counters
// Purpose: length-counter widths shared by the channel blocks.
//   LEN_WIDTH_SQ   : square/noise channel length width (6 bits)
//   LEN_WIDTH_WAVE : wave channel length width (8 bits)
package gb_apu_pkg;

  localparam int LEN_WIDTH_SQ   = 6;
  localparam int LEN_WIDTH_WAVE = 8;

endpackage

// File: rtl/gb_rising_edge.sv
// rtl/gb_rising_edge.sv - single-cycle rising-edge detector
// Purpose: one-cycle pulse on each low-to-high transition of d_i.
// Only built with GB_LENGTH_TICK_EDGE_EN; the level-tick build has no use for it.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (previous-value flop clears to 0)
//   d_i    : sampled level
//   rise_o : high for the cycle in which d_i is 1 and was 0 on the previous edge
`ifdef GB_LENGTH_TICK_EDGE_EN
module gb_rising_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule
`endif

// File: rtl/gb_length_function.sv
// rtl/gb_length_function.sv - channel length counter with enable flag
// Purpose: loads a length on start, counts length-clock ticks up to 2^WIDTH
// and drops the channel enable on wrap when length-enable (single) is set.
// Config: define GB_LENGTH_TICK_EDGE_EN to count rising edges of clk_length_ctr
//         instead of every cycle it is high.
// Ports:
//   clk            : clock
//   reset          : asynchronous active-low reset
//   clk_length_ctr : length-clock tick strobe
//   start          : channel trigger (level, priority over tick)
//   single         : 1 = stop at terminal count, 0 = play forever
//   length         : counter load value
//   enable         : registered channel-on flag
module gb_length_function
  import gb_apu_pkg::*;
#(
  parameter int WIDTH = LEN_WIDTH_SQ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_length_ctr,
  input  logic             start,
  input  logic             single,
  input  logic [WIDTH-1:0] length,
  output logic             enable
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             run_q;
  logic             tick;

  // run_q stays low through the first edge after reset release, so a tick
  // coincident with the release edge is never processed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

`ifdef GB_LENGTH_TICK_EDGE_EN
  logic tick_rise;

  gb_rising_edge u_tick_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (clk_length_ctr),
    .rise_o (tick_rise)
  );

  assign tick = tick_rise & run_q;
`else
  assign tick = clk_length_ctr & run_q;
`endif

  always_comb begin
    cnt_d = cnt_q;
    en_d  = en_q;
    if (start) begin
      // Trigger wins over a same-cycle tick; that tick is dropped.
      cnt_d = length;
      en_d  = 1'b1;
    end else if (tick && en_q && single) begin
      cnt_d = cnt_q + WIDTH'(1);
      // Wrapping from all-ones is the terminal count: enable falls on this edge.
      if (&cnt_q) begin
        en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign enable = en_q;

endmodule

// File: tb/tb_gb_length_function.sv
// tb/tb_gb_length_function.sv - self-checking bench for gb_length_function
module tb_gb_length_function;

  localparam int W    = 6;
  localparam int TERM = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clk_length_ctr = 1'b0;
  logic         start = 1'b0;
  logic         single = 1'b0;
  logic [W-1:0] length = '0;
  logic         enable;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt  = 0;
  bit m_en   = 1'b0;
  bit m_run  = 1'b0;
  bit m_prev = 1'b0;

  gb_length_function #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_length_ctr (clk_length_ctr),
    .start          (start),
    .single         (single),
    .length         (length),
    .enable         (enable)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt  = 0;
    m_en   = 1'b0;
    m_run  = 1'b0;
    m_prev = 1'b0;
  endtask

  // Channel behaviour at one clock edge: ticks remaining = TERM - count.
  task automatic model_edge();
    bit tk;
    if (!reset) begin
      model_reset();
    end else begin
`ifdef GB_LENGTH_TICK_EDGE_EN
      tk = clk_length_ctr && !m_prev && m_run;
`else
      tk = clk_length_ctr && m_run;
`endif
      m_prev = clk_length_ctr;
      if (start) begin
        m_cnt = int'(length);
        m_en  = 1'b1;
      end else if (tk && m_en && single) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == TERM) begin
          m_cnt = 0;
          m_en  = 1'b0;
        end
      end
      m_run = 1'b1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic tk);
    start          = st;
    clk_length_ctr = tk;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // one single-cycle tick followed by a low cycle
  task automatic tick_pulse();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic trigger(input logic [W-1:0] len);
    length = len;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("reset_enable", int'(enable), 0);
    check("reset_cnt", int'(dut.cnt_q), 0);
    reset = 1'b1;
    single = 1'b1;
    for (int i = 0; i < 3; i++) tick_pulse();
    check("no_start_ticks_enable", int'(enable), 0);

    // length 60, start held 2 cycles, 10 ticks
    length = 6'd60;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("start_enable", int'(enable), 1);
    check("start_cnt", int'(dut.cnt_q), 60);
    for (int i = 1; i <= 10; i++) begin
      tick_pulse();
      check($sformatf("len60_tick%0d", i), int'(enable), (i < 4) ? 1 : 0);
    end
    check("len60_cnt_after_expiry", int'(dut.cnt_q), 0);

    // single=0: plays indefinitely, count held
    single = 1'b0;
    trigger(6'd60);
    for (int i = 1; i <= 10; i++) tick_pulse();
    check("single0_enable", int'(enable), 1);
    check("single0_cnt", int'(dut.cnt_q), 60);

    // single 0 -> 1 resumes from held count (4 ticks left)
    single = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick_pulse();
      check($sformatf("resume_tick%0d", i), int'(enable), (i < 4) ? 1 : 0);
    end

    // length 0 -> 64 ticks
    trigger(6'd0);
    for (int i = 1; i <= 64; i++) begin
      tick_pulse();
      if (i == 63) check("len0_tick63", int'(enable), 1);
    end
    check("len0_tick64", int'(enable), 0);

    // length all-ones -> 1 tick
    trigger(6'd63);
    check("len63_pre", int'(enable), 1);
    tick_pulse();
    check("len63_tick1", int'(enable), 0);

    // start with tick at cnt=63
    trigger(6'd60);
    for (int i = 0; i < 3; i++) tick_pulse();
    check("cnt_at_63", int'(dut.cnt_q), 63);
    length = 6'd61;
    step(1'b1, 1'b1);
    check("start_tick_cnt", int'(dut.cnt_q), 61);
    check("start_tick_enable", int'(enable), 1);
    step(1'b0, 1'b0);
    // length change without start has no effect: still 3 ticks left
    length = 6'd0;
    for (int i = 0; i < 3; i++) tick_pulse();
    check("len_change_ignored", int'(enable), 0);
    step(1'b1, 1'b0);
    check("retrigger_enable", int'(enable), 1);
    step(1'b0, 1'b0);

    // asynchronous reset mid-count
    trigger(6'd60);
    tick_pulse();
    tick_pulse();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_enable", int'(enable), 0);
    check("async_reset_cnt", int'(dut.cnt_q), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick_pulse();
    check("post_reset_enable", int'(enable), 0);

    // tick held high for 3 cycles, 2 ticks to expiry
    trigger(6'd62);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
`ifdef GB_LENGTH_TICK_EDGE_EN
    check("wide_tick_enable", int'(enable), 1);
    check("wide_tick_cnt", int'(dut.cnt_q), 63);
`else
    check("wide_tick_enable", int'(enable), 0);
    check("wide_tick_cnt", int'(dut.cnt_q), 0);
`endif
    check("wide_tick_model_en", int'(enable), int'(m_en));

    // randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 79) != 0);
      single = ($urandom_range(0, 3) != 0);
      length = W'($urandom_range(40, 63));
      step($urandom_range(0, 23) == 0, $urandom_range(0, 1) == 1);
      check($sformatf("rand%0d_enable", i), int'(enable), int'(m_en));
      check($sformatf("rand%0d_cnt", i), int'(dut.cnt_q), m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_length_function.md
GB_LENGTH_FUNCTION -- requirements
Module: gb_length_function

Interface
- REQ-001: Parameter WIDTH, default 6: counter and length-load width; terminal count is 2^WIDTH.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately, independent of clk).
- REQ-004: clk_length_ctr  input  1  length-clock tick strobe from the frame sequencer.
- REQ-005: start  input  1  channel trigger; level-sensitive, may be held several cycles.
- REQ-006: single  input  1  length-enable; 1 = channel stops at terminal count, 0 = channel plays indefinitely.
- REQ-007: length  input  WIDTH  initial counter load value; ticks to shutoff = 2^WIDTH - length.
- REQ-008: enable  output  1  registered channel-on flag; 1 = channel audible.

Function
- REQ-009: Internal state SHALL be WIDTH-bit up-counter cnt plus the enable register; no other FSM.
- REQ-010: On every clk edge with start=1, cnt SHALL load length and enable SHALL be set to 1.
- REQ-011: start SHALL have priority over a simultaneous tick; the tick in that cycle is discarded.
- REQ-012: On a tick with start=0, enable=1, single=1: cnt SHALL increment by 1, modulo 2^WIDTH.
- REQ-013: If that increment wraps cnt from all-ones to 0, enable SHALL be 0 after that same edge.
- REQ-014: Latency from the expiring tick edge to enable=0 SHALL be zero cycles, so enable is low in the following cycle.
- REQ-015: With single=0, ticks SHALL NOT change cnt, and enable SHALL remain 1.
- REQ-016: Changing single from 0 to 1 mid-play SHALL resume counting from the held cnt.
- REQ-017: With enable=0, ticks SHALL NOT change cnt; only start re-enables the channel.
- REQ-018: length=0 SHALL give 2^WIDTH ticks to shutoff; length=all-ones SHALL give 1 tick.
- REQ-019: Changing length without start SHALL have no effect.

Reset
- REQ-020: reset=0 SHALL asynchronously force cnt=0 and enable=0.
- REQ-021: Reset asserted mid-count SHALL abort the count; after release, enable SHALL stay 0 until start.
- REQ-022: Reset release SHALL be synchronized so that no tick is processed on the release edge.

Configuration
- REQ-023: Macro GB_LENGTH_TICK_EDGE_EN defined: a tick SHALL be the rising edge of clk_length_ctr, detected by a registered previous-value flop that resets to 0, so one tick occurs per high pulse regardless of width.
- REQ-024: Macro GB_LENGTH_TICK_EDGE_EN undefined: a tick SHALL occur on every clk edge with clk_length_ctr=1.
- REQ-025: With single-cycle tick pulses, both builds SHALL behave identically.

Structure
- REQ-026: Shared package gb_apu_pkg SHALL hold the default length width constant (6, square/noise channels) and the wave-channel width constant (8).
- REQ-027: The rising-edge detector SHALL be a sub-module gb_rising_edge, instantiated only when GB_LENGTH_TICK_EDGE_EN is defined.
- REQ-028: The counter and enable logic SHALL reside in gb_length_function.

Verification
- REQ-029: reset=0, then release -> enable=0, cnt=0; ticks without start leave enable=0.
- REQ-030: WIDTH=6, single=1, length=60, start for 2 cycles, then 10 single-cycle ticks -> enable=1 after ticks 1-3, enable=0 after tick 4, and enable stays 0 through tick 10.
- REQ-031: Same setup but single=0, 10 ticks -> enable=1 throughout, cnt stays 60.
- REQ-032: length=0, single=1 -> enable falls exactly after tick 64; length=63 -> enable falls after tick 1.
- REQ-033: start and tick in the same cycle with cnt=63 -> cnt=length, enable=1; re-trigger after expiry restores enable=1.
- REQ-034: Reset pulsed after 2 of 4 ticks -> enable=0 immediately, without waiting for a clk edge; with GB_LENGTH_TICK_EDGE_EN defined, a 3-cycle-high tick counts once.
